// File: rtl/paint_ctrl_brush_pkg.sv
// Shared types for the brush paint controller: FSM encoding, eraser value and colour packing.
package paint_pkg;

    typedef enum logic [3:0] {
        IDLE            = 4'd0,
        INIT            = 4'd1,
        CHECK_C         = 4'd2,
        CHECK_ENTER     = 4'd3,
        DRAW_CURSOR     = 4'd4,
        CURSOR_PAL      = 4'd5,
        CHECK_ENTER_PAL = 4'd6,
        CHANGE_COLOR    = 4'd7,
        STAMP           = 4'd8,
        STAMP_END       = 4'd9
    } paint_state_t;

    localparam int ERASE_COLOR = 0;

    // Packs the low 'half' bits of y above the low 'half' bits of x.
    function automatic logic [31:0] compose_color(input logic [15:0] x, input logic [15:0] y,
                                                  input int half);
        logic [31:0] m;
        m = (32'd1 << half) - 32'd1;
        return (({16'd0, y} & m) << half) | ({16'd0, x} & m);
    endfunction

endpackage

// File: rtl/paint_ctrl_brush_if.sv
// Write handshake from the paint controller toward the frame-buffer writer.
interface paint_ctrl_brush_if #(
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int COLOR_W = 8
);
    logic [X_W-1:0]     out_x;
    logic [Y_W-1:0]     out_y;
    logic [COLOR_W-1:0] px_data;
    logic               wr_valid;
    logic               wr_ready;

    modport master (output out_x, out_y, px_data, wr_valid, input wr_ready);
    modport slave  (input out_x, out_y, px_data, wr_valid, output wr_ready);
endinterface

// File: rtl/paint_ctrl_brush_walker.sv
// Row-major S x S walk over the brush footprint with one-bit-wider targets for clipping.
module brush_walker #(
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int COLS    = 64,
    parameter int ROWS    = 64,
    parameter int BRUSH_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             advance,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [BRUSH_W:0] s,
    output logic [X_W:0]     tx,
    output logic [Y_W:0]     ty,
    output logic             in_range,
    output logic             last
);
    logic [X_W-1:0]     bx;
    logic [Y_W-1:0]     by;
    logic [BRUSH_W-1:0] dx, dy, smax;

    always_ff @(negedge clk) begin
        if (rst) begin
            bx   <= '0;
            by   <= '0;
            dx   <= '0;
            dy   <= '0;
            smax <= '0;
        end else if (start) begin
            bx   <= x0;
            by   <= y0;
            dx   <= '0;
            dy   <= '0;
            smax <= BRUSH_W'(s - 1'b1);
        end else if (advance) begin
            if (dx == smax) begin
                dx <= '0;
                dy <= dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

    assign tx       = {1'b0, bx} + (X_W+1)'(dx);
    assign ty       = {1'b0, by} + (Y_W+1)'(dy);
    assign in_range = (tx < (X_W+1)'(COLS)) && (ty < (Y_W+1)'(ROWS));
    assign last     = (dx == smax) && (dy == smax);
endmodule

// File: rtl/paint_ctrl_brush.sv
// Paint controller FSM with square brush stamping; PAINT_ERASER_EN adds the erase input.
module paint_ctrl_brush
    import paint_pkg::*;
#(
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int COLS    = 64,
    parameter int ROWS    = 64,
    parameter int COLOR_W = 8,
    parameter int BRUSH_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [X_W-1:0]     in_x,
    input  logic [Y_W-1:0]     in_y,
    input  logic [BRUSH_W-1:0] brush_sel,
    input  logic               w_C,
    input  logic               w_Enter,
    input  logic               w_Enter_Paleta,
    input  logic               cursor_done,
    input  logic               cursor_paleta_done,
    input  logic [COLOR_W-1:0] px_data_cursor,
    input  logic [COLOR_W-1:0] px_data_cursor_paleta,
`ifdef PAINT_ERASER_EN
    input  logic               erase,
`endif
    paint_ctrl_brush_if.master wr,
    output logic               Cursor_S,
    output logic               Cursor_Paleta_S,
    output logic               paleta,
    output logic               compC,
    output logic               compEnt,
    output logic               compPal,
    output logic               busy,
    output logic [COLOR_W-1:0] color
);
    paint_state_t       state;
    logic [X_W-1:0]     x_r;
    logic [Y_W-1:0]     y_r;
    logic [COLOR_W-1:0] px_r, color_r, stamp_val;
    logic [X_W:0]       tx;
    logic [Y_W:0]       ty;
    logic               in_range, last, start, advance;

`ifdef PAINT_ERASER_EN
    assign stamp_val = erase ? COLOR_W'(ERASE_COLOR) : color_r;
`else
    assign stamp_val = color_r;
`endif

    assign start   = (state == CHECK_ENTER) && w_Enter;
    // Clipped targets spend one cycle and move on without waiting for the writer.
    assign advance = (state == STAMP) && (!in_range || wr.wr_ready);

    brush_walker #(
        .X_W(X_W), .Y_W(Y_W), .COLS(COLS), .ROWS(ROWS), .BRUSH_W(BRUSH_W)
    ) u_walker (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .advance  (advance),
        .x0       (in_x),
        .y0       (in_y),
        .s        ({1'b0, brush_sel} + 1'b1),
        .tx       (tx),
        .ty       (ty),
        .in_range (in_range),
        .last     (last)
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
            px_r    <= '0;
            color_r <= '0;
        end else begin
            case (state)
                IDLE:            if (init) state <= INIT;
                INIT: begin
                    x_r   <= in_x;
                    y_r   <= in_y;
                    state <= CHECK_C;
                end
                CHECK_C:         state <= w_C ? CURSOR_PAL : CHECK_ENTER;
                CHECK_ENTER: begin
                    if (w_Enter) begin
                        px_r  <= stamp_val;
                        state <= STAMP;
                    end else begin
                        state <= DRAW_CURSOR;
                    end
                end
                DRAW_CURSOR: begin
                    px_r <= px_data_cursor;
                    if (cursor_done) state <= INIT;
                end
                CURSOR_PAL: begin
                    px_r <= px_data_cursor_paleta;
                    if (cursor_paleta_done) state <= CHECK_ENTER_PAL;
                end
                CHECK_ENTER_PAL: state <= w_Enter_Paleta ? CHANGE_COLOR : CURSOR_PAL;
                CHANGE_COLOR: begin
                    color_r <= COLOR_W'(compose_color(16'(in_x), 16'(in_y), COLOR_W/2));
                    state   <= INIT;
                end
                STAMP:           if (advance && last) state <= STAMP_END;
                STAMP_END:       state <= INIT;
                default:         state <= IDLE;
            endcase
        end
    end

    // During a stamp the walker's target is the write address; otherwise the cursor latch.
    assign wr.out_x    = (state == STAMP) ? tx[X_W-1:0] : x_r;
    assign wr.out_y    = (state == STAMP) ? ty[Y_W-1:0] : y_r;
    assign wr.px_data  = px_r;
    assign wr.wr_valid = (state == STAMP) && in_range;

    assign Cursor_S        = (state == DRAW_CURSOR);
    assign Cursor_Paleta_S = (state == CURSOR_PAL);
    assign paleta          = (state == CURSOR_PAL);
    assign compC           = (state == CHECK_C);
    assign compEnt         = (state == CHECK_ENTER);
    assign compPal         = (state == CHECK_ENTER_PAL);
    assign busy            = (state != IDLE);
    assign color           = color_r;
endmodule

// File: tb/tb_paint_ctrl_brush.sv
// Directed bench for paint_ctrl_brush: stamp vector table plus palette, stall and reset sequences.
module tb_paint_ctrl_brush;
    localparam int X_W = 6, Y_W = 6, COLOR_W = 8, BRUSH_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b0;
    logic [X_W-1:0] in_x = '0;
    logic [Y_W-1:0] in_y = '0;
    logic [BRUSH_W-1:0] brush_sel = '0;
    logic w_C = 1'b0, w_Enter = 1'b0, w_Enter_Paleta = 1'b0;
    logic cursor_done = 1'b1, cursor_paleta_done = 1'b0;
    logic [COLOR_W-1:0] px_data_cursor = '0, px_data_cursor_paleta = '0;
`ifdef PAINT_ERASER_EN
    logic erase = 1'b0;
`endif
    logic Cursor_S, Cursor_Paleta_S, paleta, compC, compEnt, compPal, busy;
    logic [COLOR_W-1:0] color;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    paint_ctrl_brush_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) wr();

    paint_ctrl_brush #(
        .X_W(X_W), .Y_W(Y_W), .COLS(64), .ROWS(64), .COLOR_W(COLOR_W), .BRUSH_W(BRUSH_W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .init                  (init),
        .in_x                  (in_x),
        .in_y                  (in_y),
        .brush_sel             (brush_sel),
        .w_C                   (w_C),
        .w_Enter               (w_Enter),
        .w_Enter_Paleta        (w_Enter_Paleta),
        .cursor_done           (cursor_done),
        .cursor_paleta_done    (cursor_paleta_done),
        .px_data_cursor        (px_data_cursor),
        .px_data_cursor_paleta (px_data_cursor_paleta),
`ifdef PAINT_ERASER_EN
        .erase                 (erase),
`endif
        .wr                    (wr),
        .Cursor_S              (Cursor_S),
        .Cursor_Paleta_S       (Cursor_Paleta_S),
        .paleta                (paleta),
        .compC                 (compC),
        .compEnt               (compEnt),
        .compPal               (compPal),
        .busy                  (busy),
        .color                 (color)
    );

    typedef struct {
        int x, y, bs;
        int stall_pix, stall_n;
        int exp_wr, exp_clip;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Waits for a state strobe at a rising edge (the DUT updates on the falling edge).
    task automatic wait_for(input int w, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            case (w)
                0: ok = compC;
                1: ok = compEnt;
                2: ok = compPal;
                3: ok = Cursor_S;
                default: ok = 1'b0;
            endcase
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait %s: strobe never seen, expected within 100 cycles", nm);
        end
    endtask

    task automatic run_stamp(input int x, input int y, input int bs, input int stall_pix,
                             input int stall_n, input int exp_wr, input int exp_clip,
                             input int exp_data, input string nm);
        int ex[$];
        int ey[$];
        int k, held, cyc, clip;
        bit done;
        for (int dy = 0; dy <= bs; dy++)
            for (int dx = 0; dx <= bs; dx++)
                if (x + dx < 64 && y + dy < 64) begin
                    ex.push_back(x + dx);
                    ey.push_back(y + dy);
                end
        in_x = X_W'(x);
        in_y = Y_W'(y);
        brush_sel = BRUSH_W'(bs);
        w_C = 1'b0;
        wr.wr_ready = 1'b1;
        wait_for(0, {nm, " compC"});
        w_Enter = 1'b1;
        wait_for(1, {nm, " compEnt"});
        k = 0; held = 0; cyc = 0; clip = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            if (compC) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (wr.wr_valid) begin
                    if (k < ex.size()) begin
                        chk({nm, " x"}, int'(wr.out_x), ex[k]);
                        chk({nm, " y"}, int'(wr.out_y), ey[k]);
                        chk({nm, " data"}, int'(wr.px_data), exp_data);
                    end else begin
                        chk({nm, " extra write"}, k, ex.size() - 1);
                    end
                    if (k == stall_pix) held++;
                    wr.wr_ready = !(k == stall_pix && held <= stall_n);
                    if (wr.wr_ready) k++;
                end else begin
                    clip++;
                    wr.wr_ready = 1'b1;
                end
            end
        end
        w_Enter = 1'b0;
        wr.wr_ready = 1'b1;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s end: no return to CHECK_C, expected within 200 cycles", nm);
        end
        chk({nm, " writes"}, k, exp_wr);
        chk({nm, " idle cycles"}, clip, exp_clip + 2);
        chk({nm, " cycles"}, cyc, (bs + 1) * (bs + 1) + stall_n + 2);
        if (stall_pix >= 0) chk({nm, " held"}, held, stall_n + 1);
    endtask

    task automatic set_palette(input int x, input int y, input int exp);
        w_Enter = 1'b0;
        w_C = 1'b0;
        cursor_paleta_done = 1'b0;
        px_data_cursor_paleta = 8'h77;
        wait_for(0, "pal compC");
        w_C = 1'b1;
        @(posedge clk);
        chk("pal Cursor_Paleta_S", int'(Cursor_Paleta_S), 1);
        chk("pal paleta", int'(paleta), 1);
        w_C = 1'b0;
        @(posedge clk);
        chk("pal px_data", int'(wr.px_data), 8'h77);
        cursor_paleta_done = 1'b1;
        wait_for(2, "pal compPal");
        cursor_paleta_done = 1'b0;
        in_x = X_W'(x);
        in_y = Y_W'(y);
        w_Enter_Paleta = 1'b1;
        @(posedge clk);
        w_Enter_Paleta = 1'b0;
        @(posedge clk);
        chk("pal color", int'(color), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        //         x   y  bs stall_pix stall_n wr clip
        vecs[0] = '{10, 20, 0, -1, 0, 1,  0};
        vecs[1] = '{62, 62, 3, -1, 0, 4, 12};
        vecs[2] = '{30, 40, 1,  1, 3, 4,  0};
        vecs[3] = '{63, 10, 2, -1, 0, 3,  6};
        vecs[4] = '{ 0, 63, 1, -1, 0, 2,  2};
        wr.wr_ready = 1'b1;

        repeat (3) @(posedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst wr_valid", int'(wr.wr_valid), 0);
        chk("rst out_x", int'(wr.out_x), 0);
        chk("rst out_y", int'(wr.out_y), 0);
        chk("rst px_data", int'(wr.px_data), 0);
        chk("rst color", int'(color), 0);
        chk("rst strobes", int'({Cursor_S, Cursor_Paleta_S, paleta, compC, compEnt, compPal}), 0);
        rst = 1'b0;
        init = 1'b1;

        // Cursor path: px_data follows the cursor renderer while drawing.
        cursor_done = 1'b0;
        px_data_cursor = 8'h3C;
        wait_for(3, "cursor Cursor_S");
        @(posedge clk);
        chk("cursor px_data", int'(wr.px_data), 8'h3C);
        chk("cursor Cursor_S held", int'(Cursor_S), 1);
        cursor_done = 1'b1;

        set_palette(5, 10, 8'hA5);

        for (int i = 0; i < 5; i++)
            run_stamp(vecs[i].x, vecs[i].y, vecs[i].bs, vecs[i].stall_pix, vecs[i].stall_n,
                      vecs[i].exp_wr, vecs[i].exp_clip, 8'hA5, $sformatf("vec%0d", i));

        // Reset during the third pixel of a 4x4 stamp abandons the rest.
        in_x = 6'd10;
        in_y = 6'd10;
        brush_sel = 2'd3;
        wait_for(0, "rstmid compC");
        w_Enter = 1'b1;
        wait_for(1, "rstmid compEnt");
        repeat (3) @(posedge clk);
        chk("rstmid pixel3 valid", int'(wr.wr_valid), 1);
        chk("rstmid pixel3 x", int'(wr.out_x), 12);
        rst = 1'b1;
        w_Enter = 1'b0;
        @(posedge clk);
        chk("rstmid wr_valid", int'(wr.wr_valid), 0);
        chk("rstmid busy", int'(busy), 0);
        chk("rstmid out_x", int'(wr.out_x), 0);
        chk("rstmid out_y", int'(wr.out_y), 0);
        chk("rstmid px_data", int'(wr.px_data), 0);
        chk("rstmid color", int'(color), 0);
        rst = 1'b0;

`ifdef PAINT_ERASER_EN
        set_palette(5, 10, 8'hA5);
        erase = 1'b1;
        run_stamp(20, 20, 1, -1, 0, 4, 0, 0, "erase");
        erase = 1'b0;
        chk("erase color kept", int'(color), 8'hA5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
